// File: rtl/halton_index_decoder.sv
// halton_index_decoder
//
// Recovers the sequence index k from one 2-D fixed-point Halton point
// (bases 2 and 3) by digit reversal, one digit per cycle per lane.
// Also flags inputs outside each lane's scaled range and reports whether
// the two lanes decoded to different indices.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     a point is offered on halton_in_0/1
//   in_ready     decoder can accept a point (IDLE only)
//   halton_in_0  base-2 scaled value, legal range [0, 2^SCALE_0)
//   halton_in_1  base-3 scaled value, legal range [0, 3^SCALE_1)
//   out_valid    decoded result is presented (DONE)
//   out_ready    consumer accepts the result
//   k_out_0      index recovered from lane 0
//   k_out_1      index recovered from lane 1
//   range_err    bit j set when lane j input >= base_j^SCALE_j
//   mismatch     k_out_0 != k_out_1 (meaningful while out_valid)
module halton_index_decoder #(
    parameter int SCALE_0 = 11,
    parameter int SCALE_1 = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] halton_in_0,
    input  logic [31:0] halton_in_1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] k_out_0,
    output logic [31:0] k_out_1,
    output logic [1:0]  range_err,
    output logic        mismatch
);

    // 3^n evaluated at elaboration time for the lane-1 range limit.
    function automatic logic [63:0] pow3(input int n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd3;
        end
        return acc;
    endfunction

    // Exact floor(v/3) for any 32-bit v: 0xAAAAAAAB = (2^33 + 1) / 3.
    function automatic logic [31:0] div3(input logic [31:0] v);
        logic [63:0] prod;
        prod = {32'd0, v} * 64'hAAAA_AAAB;
        return 32'(prod >> 33);
    endfunction

    localparam int              MAX_SCALE = (SCALE_0 > SCALE_1) ? SCALE_0 : SCALE_1;
    localparam int              CW        = 5;
    localparam logic [63:0]     LIMIT_0   = 64'd1 << SCALE_0;
    localparam logic [63:0]     LIMIT_1   = pow3(SCALE_1);
    localparam logic [CW-1:0]   STEPS_0   = CW'(SCALE_0);
    localparam logic [CW-1:0]   STEPS_1   = CW'(SCALE_1);
    localparam logic [CW-1:0]   LAST_CNT  = CW'(MAX_SCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   rem0_r;
    logic [31:0]   rem1_r;
    logic [31:0]   k0_r;
    logic [31:0]   k1_r;
    logic [1:0]    err_r;
    logic          in_ready_r;
    logic          out_valid_r;

    logic [31:0]   q1_s;
    logic [31:0]   d1_s;
    logic [1:0]    err_s;

    // Base-3 digit extraction and range check on the raw inputs.
    always_comb begin
        q1_s     = div3(rem1_r);
        d1_s     = rem1_r - (q1_s * 32'd3);
        err_s[0] = ({32'd0, halton_in_0} >= LIMIT_0);
        err_s[1] = ({32'd0, halton_in_1} >= LIMIT_1);
    end

    // Control FSM plus both digit-reversal datapaths; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            rem0_r      <= 32'd0;
            rem1_r      <= 32'd0;
            k0_r        <= 32'd0;
            k1_r        <= 32'd0;
            err_r       <= 2'b00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        rem0_r     <= halton_in_0;
                        rem1_r     <= halton_in_1;
                        err_r      <= err_s;
                        k0_r       <= 32'd0;
                        k1_r       <= 32'd0;
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    // Input LSB digit becomes the most significant digit of k.
                    if (cnt_r < STEPS_0) begin
                        k0_r   <= {k0_r[30:0], rem0_r[0]};
                        rem0_r <= rem0_r >> 1;
                    end
                    if (cnt_r < STEPS_1) begin
                        k1_r   <= (k1_r * 32'd3) + d1_s;
                        rem1_r <= q1_s;
                    end
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign k_out_0   = k0_r;
    assign k_out_1   = k1_r;
    assign range_err = err_r;
    assign mismatch  = (k0_r != k1_r);

endmodule
